// File: rtl/seq_alu.sv
// Registered LEGv8-style ALU with valid/ready handshakes, NZCV flags,
// logical shifts and an optional iterative shift-add multiplier.
module seq_alu #(
    parameter int WIDTH      = 64,
    parameter int MUL_ENABLE = 1
) (
    input  logic             input_clk,
    input  logic             input_reset,
    input  logic             input_valid,
    output logic             output_ready,
    input  logic [WIDTH-1:0] input_data_1,
    input  logic [WIDTH-1:0] input_data_2,
    input  logic [3:0]       input_opcode,
    output logic             output_valid,
    input  logic             input_result_ready,
    output logic [WIDTH-1:0] output_data,
    output logic             output_zero,
    output logic             output_negative,
    output logic             output_carry,
    output logic             output_overflow,
    output logic             output_illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W + 1)'(WIDTH);
    localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W + 1)'(1);

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_MUL   = 4'b1000,
        OP_LSL   = 4'b1001,
        OP_LSR   = 4'b1010,
        OP_NOR   = 4'b1100
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_ovf;
    logic             r_ill;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [SHAMT_W:0] r_cnt;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_start_mul;
    logic               w_mul_done;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_ill;
    logic [WIDTH-1:0]   w_prod;

    assign w_accept    = input_valid && output_ready;
    assign w_is_mul    = (input_opcode == OP_MUL) && (MUL_ENABLE != 0);
    assign w_start_mul = w_accept && w_is_mul;
    assign w_mul_done  = (r_state == S_MUL) && (r_cnt == CNT_LAST);

    assign w_add   = {1'b0, input_data_1} + {1'b0, input_data_2};
    assign w_sub   = {1'b0, input_data_1} + {1'b0, ~input_data_2} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = input_data_2[SHAMT_W-1:0];

    // Final iteration folds its partial product straight into the registered result.
    assign w_prod = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (input_opcode)
            OP_AND:   w_res = input_data_1 & input_data_2;
            OP_OR:    w_res = input_data_1 | input_data_2;
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (input_data_1[WIDTH-1] == input_data_2[WIDTH-1]) &&
                        (w_add[WIDTH-1] != input_data_1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (input_data_1[WIDTH-1] != input_data_2[WIDTH-1]) &&
                        (w_sub[WIDTH-1] != input_data_1[WIDTH-1]);
            end
            OP_PASSB: w_res = input_data_2;
            OP_NOR:   w_res = ~(input_data_1 | input_data_2);
            OP_LSL:   w_res = input_data_1 << w_shamt;
            OP_LSR:   w_res = input_data_1 >> w_shamt;
            OP_MUL:   w_ill = (MUL_ENABLE == 0);
            default:  w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_is_mul ? S_MUL : S_HOLD;
                end
            end
            S_MUL: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    w_next_state = w_is_mul ? S_MUL : S_HOLD;
                end else if (input_result_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        output_ready = 1'b0;
        output_valid = 1'b0;
        case (r_state)
            S_IDLE: output_ready = 1'b1;
            S_HOLD: begin
                output_ready = input_result_ready;
                output_valid = 1'b1;
            end
            default: begin
                output_ready = 1'b0;
                output_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            r_data   <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_start_mul) begin
            r_mcand  <= input_data_1;
            r_mplier <= input_data_2;
            r_acc    <= '0;
            r_cnt    <= CNT_INIT;
        end else if (w_accept) begin
            r_data  <= w_res;
            r_zero  <= (w_res == '0);
            r_neg   <= w_res[WIDTH-1];
            r_carry <= w_c;
            r_ovf   <= w_v;
            r_ill   <= w_ill;
        end else if (w_mul_done) begin
            r_data  <= w_prod;
            r_zero  <= (w_prod == '0);
            r_neg   <= w_prod[WIDTH-1];
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_LAST;
        end
    end

    assign output_data     = r_data;
    assign output_zero     = r_zero;
    assign output_negative = r_neg;
    assign output_carry    = r_carry;
    assign output_overflow = r_ovf;
    assign output_illegal  = r_ill;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: table of single-cycle vectors plus hand-written
// multiply, backpressure and reset-abort sequences; a MUL_ENABLE=0 copy rides along.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        res_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;

    logic        ready, valid, zf, nf, cf, vf, illf;
    logic [63:0] data;
    logic        nm_ready, nm_valid, nm_zf, nm_nf, nm_cf, nm_vf, nm_illf;
    logic [63:0] nm_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(64), .MUL_ENABLE(1)) dut (
        .input_clk(clk), .input_reset(rst), .input_valid(in_valid), .output_ready(ready),
        .input_data_1(a), .input_data_2(b), .input_opcode(op), .output_valid(valid),
        .input_result_ready(res_ready), .output_data(data), .output_zero(zf),
        .output_negative(nf), .output_carry(cf), .output_overflow(vf), .output_illegal(illf)
    );

    seq_alu #(.WIDTH(64), .MUL_ENABLE(0)) dut_nomul (
        .input_clk(clk), .input_reset(rst), .input_valid(in_valid), .output_ready(nm_ready),
        .input_data_1(a), .input_data_2(b), .input_opcode(op), .output_valid(nm_valid),
        .input_result_ready(res_ready), .output_data(nm_data), .output_zero(nm_zf),
        .output_negative(nm_nf), .output_carry(nm_cf), .output_overflow(nm_vf),
        .output_illegal(nm_illf)
    );

    // flags packed as {Z, N, C, V, illegal}
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] d;
        logic [4:0]  f;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [4:0] flags();
        return {zf, nf, cf, vf, illf};
    endfunction

    task automatic run_mul(input string name, input logic [63:0] ma, input logic [63:0] mb,
                           input logic [63:0] exp);
        int   edges;
        logic saw_ready;
        @(negedge clk);
        op = 4'b1000; a = ma; b = mb; in_valid = 1'b1;
        chk({name, " ready_at_accept"}, ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, " nomul_illegal"}, {nm_valid, nm_illf, nm_zf}, 3'b111);
        chk({name, " nomul_data"}, nm_data, 64'h0);
        edges = 0;
        saw_ready = 1'b0;
        while (!valid && edges < 200) begin
            if (ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        chk({name, " latency"}, edges, 64);
        chk({name, " ready_low_during"}, saw_ready, 0);
        chk({name, " data"}, data, exp);
        chk({name, " flags"}, flags(), {(exp == 64'h0), exp[63], 3'b000});
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"add_5_7",     4'b0010, 64'd5,                  64'd7,                  64'd12,                 5'b00000};
        vecs[1]  = '{"sub_9_9",     4'b0110, 64'd9,                  64'd9,                  64'd0,                  5'b10100};
        vecs[2]  = '{"sub_0_1",     4'b0110, 64'd0,                  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 5'b01000};
        vecs[3]  = '{"add_ovf",     4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                  64'h8000_0000_0000_0000, 5'b01010};
        vecs[4]  = '{"lsl_3",       4'b1001, 64'd1,                  64'h43,                 64'd8,                  5'b00000};
        vecs[5]  = '{"lsr_63",      4'b1010, 64'h8000_0000_0000_0000, 64'h3F,                 64'd1,                  5'b00000};
        vecs[6]  = '{"illegal_f",   4'b1111, 64'd3,                  64'd4,                  64'd0,                  5'b10001};
        vecs[7]  = '{"and",         4'b0000, 64'hF0F0,               64'hFF00,               64'hF000,               5'b00000};
        vecs[8]  = '{"or",          4'b0001, 64'hF0,                 64'h0F,                 64'hFF,                 5'b00000};
        vecs[9]  = '{"nor_zero",    4'b1100, 64'd0,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 5'b01000};
        vecs[10] = '{"pass_b",      4'b0111, 64'd123,                64'h5A,                 64'h5A,                 5'b00000};
        vecs[11] = '{"add_carry",   4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd0,                  5'b10100};
        vecs[12] = '{"sub_ovf",     4'b0110, 64'h8000_0000_0000_0000, 64'd1,                  64'h7FFF_FFFF_FFFF_FFFF, 5'b00110};
        vecs[13] = '{"illegal_3",   4'b0011, 64'd1,                  64'd1,                  64'd0,                  5'b10001};

        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset valid", valid, 0);
        chk("reset ready", ready, 1);
        chk("reset data", data, 64'h0);
        chk("reset flags", flags(), 5'b00000);

        // Back-to-back vectors: each accept after the first lands in HOLD with a consume.
        foreach (vecs[i]) begin
            @(negedge clk);
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
            chk({vecs[i].name, " ready"}, ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({vecs[i].name, " valid"}, valid, 1);
            chk({vecs[i].name, " data"}, data, vecs[i].d);
            chk({vecs[i].name, " flags"}, flags(), vecs[i].f);
        end

        run_mul("mul_3_5", 64'd3, 64'd5, 64'd15);
        run_mul("mul_ones_2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);

        // Backpressure: ADD held five cycles while a competing OR waits.
        @(posedge clk); #1;
        chk("drain to idle", {valid, ready}, 2'b01);
        res_ready = 1'b0; op = 4'b0010; a = 64'd5; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'b0001; a = 64'hF0; b = 64'h0F;
        for (int k = 0; k < 5; k++) begin
            chk("bp data", data, 64'd12);
            chk("bp flags", flags(), 5'b00000);
            chk("bp valid_ready", {valid, ready}, 2'b10);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        #1 chk("bp ready_follows", ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp replace valid", valid, 1);
        chk("bp replace data", data, 64'hFF);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        op = 4'b1000; a = 64'd3; b = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort valid_ready", {valid, ready}, 2'b01);
        chk("abort data", data, 64'h0);
        chk("abort flags", flags(), 5'b00000);
        op = 4'b0010; a = 64'd1; b = 64'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_abort valid", valid, 1);
        chk("post_abort data", data, 64'd2);
        repeat (70) @(posedge clk);
        #1 chk("no stale product", {valid, data}, {1'b0, 64'd2});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the single-cycle 64-bit datapath ALU. It supports the full LEGv8 ALU-control opcode set, plus an iterative multiplier and logical shifts. Results and 1-bit NZCV flags are registered behind a valid/ready handshake on both sides. It sits between the register-file read stage and writeback, and can stall the pipeline during multi-cycle operations.

Parameters:
WIDTH, 64, datapath width in bits; power of two, at least 8.
MUL_ENABLE, 1, 1 = opcode 1000 performs a multiply; 0 = opcode 1000 is illegal.
SHAMT_W, $clog2(WIDTH), derived local width of the shift amount; not overridable.

Ports:
input_clk  in  1  clock; all state updates on the rising edge.
input_reset  in  1  synchronous, active-high reset.
input_valid  in  1  operand and opcode presented.
output_ready  out  1  block accepts an operation this cycle.
input_data_1  in  WIDTH  operand A.
input_data_2  in  WIDTH  operand B; low SHAMT_W bits give the shift amount.
input_opcode  in  4  operation select.
output_valid  out  1  result and flags valid.
input_result_ready  in  1  consumer takes the result this cycle.
output_data  out  WIDTH  result.
output_zero  out  1  result == 0.
output_negative  out  1  result[WIDTH-1].
output_carry  out  1  carry out (ADD/SUB only).
output_overflow  out  1  signed overflow (ADD/SUB only).
output_illegal  out  1  opcode not supported.

Behaviour:
- Reset (input_reset high at an edge): state IDLE; output_valid, output_data, all flags and output_illegal = 0. Reset aborts any multiply in progress; the operation is discarded and no result is produced.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A-B); 0111 pass B; 1100 NOR.
  - 1001 LSL (A << shamt); 1010 LSR (A >> shamt, zero fill).
  - 1000 MUL: low WIDTH bits of A*B.
  - Any other opcode: output_data = 0, output_illegal = 1, output_zero = 1, all other flags 0. Completes like a single-cycle operation.
- Flags:
  - output_zero and output_negative are computed from the final result for every operation.
  - ADD: output_carry = carry out of the MSB.
  - SUB: output_carry = NOT borrow (so A >= B unsigned gives 1).
  - output_overflow = signed overflow for ADD/SUB.
  - output_carry and output_overflow are 0 for all other operations.
- States:
  - IDLE: no result held. output_ready = 1, output_valid = 0.
  - MUL: iterative shift-add multiply, one partial product per cycle, internal counter WIDTH down to 1. output_ready = 0, output_valid = 0.
  - HOLD: result registered. output_valid = 1; output_ready = input_result_ready.
- Accept: an operation is accepted on an edge where input_valid && output_ready. Operands and opcode are captured at that edge; inputs are don't-care afterwards.
- Transitions:
  - Single-cycle op accepted from IDLE or HOLD: result registered at the same edge; next state HOLD. Latency is one edge; output_valid is high in the cycle after acceptance.
  - MUL accepted from IDLE or HOLD: enter MUL. After exactly WIDTH further edges, enter HOLD with the product registered.
  - HOLD with input_result_ready=1 and no new accept: go to IDLE, output_valid drops.
  - HOLD with input_result_ready=0: all outputs frozen, no accept.
- Simultaneous events:
  - In HOLD, a consume and a new accept on the same edge are legal. The new result replaces the old one; output_valid stays 1. Sustained throughput is one single-cycle op per clock.
  - input_reset wins over every other event.
- Outputs are registered; there are no combinational paths from data inputs to data outputs. output_ready depends combinationally on input_result_ready only.

Test Plan:
- WIDTH=64, ADD 5+7, result ready held high -> output_data=12, Z=0, N=0, C=0, V=0, output_valid high exactly one cycle after accept.
- SUB 9-9 -> data 0, Z=1, C=1. SUB 0-1 -> data all ones, N=1, C=0. ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> 0x8000_0000_0000_0000, N=1, V=1, C=0.
- MUL 3*5 -> output_ready low for 64 cycles; output_valid rises 64 edges after accept with data 15. MUL 0xFFFF_FFFF_FFFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE. With MUL_ENABLE=0, opcode 1000 -> output_illegal=1, data 0.
- Backpressure: ADD result held with input_result_ready=0 for 5 cycles -> data and flags stable, output_ready=0. Then raise result ready together with input_valid (OR 0xF0|0x0F) -> next cycle data 0xFF, valid continuous.
- Reset asserted at cycle 10 of a MUL -> next cycle IDLE, all outputs 0, output_ready=1. A following ADD 1+1 gives 2 with no stale product.
- LSL A=1, B=0x43 (shamt 3 at WIDTH=64) -> data 8. LSR A=0x8000_0000_0000_0000, shamt 63 -> data 1. Illegal opcode 1111 -> output_illegal=1, Z=1.
